// File: rtl/operand_gen_multi.sv
// rtl/operand_gen_multi.sv - multi-slot operand resolution against a register status table
// Resolves each source to a value or ROB tag and registers the group into a valid/ready stage.
module operand_gen_multi #(
    parameter int ISSUE_WIDTH = 2,
    parameter int TAG_WIDTH   = 4,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [ISSUE_WIDTH-1:0]              slot_valid,
    input  logic [ISSUE_WIDTH-1:0]              src_en_1,
    input  logic [ISSUE_WIDTH-1:0]              src_en_2,
    input  logic [5*ISSUE_WIDTH-1:0]            src_addr_1,
    input  logic [5*ISSUE_WIDTH-1:0]            src_addr_2,
    input  logic [ISSUE_WIDTH-1:0]              dst_en,
    input  logic [5*ISSUE_WIDTH-1:0]            dst_addr,
    input  logic [TAG_WIDTH*ISSUE_WIDTH-1:0]    dst_tag,
    output logic [2*ISSUE_WIDTH-1:0]            reg_read_en,
    output logic [10*ISSUE_WIDTH-1:0]           reg_read_addr,
    input  logic [2*DATA_WIDTH*ISSUE_WIDTH-1:0] reg_read_data,
    input  logic                                commit_en,
    input  logic [4:0]                          commit_addr,
    input  logic [TAG_WIDTH-1:0]                commit_tag,
    input  logic [DATA_WIDTH-1:0]               commit_data,
    input  logic                                flush,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ISSUE_WIDTH-1:0]              out_slot_valid,
    output logic [2*ISSUE_WIDTH-1:0]            operand_is_ref,
    output logic [2*DATA_WIDTH*ISSUE_WIDTH-1:0] operand_data
);

    logic [31:0]                        pend_q;
    logic [32*TAG_WIDTH-1:0]            tag_q;
    logic                               accept;
    logic                               take;
    logic [2*ISSUE_WIDTH-1:0]           is_ref_d;
    logic [2*DATA_WIDTH*ISSUE_WIDTH-1:0] data_d;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign take     = accept && !flush;

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
        for (genvar s = 0; s < 2; s++) begin : g_src
            localparam int P = 2 * k + s;
            logic                  en;
            logic [4:0]            r;
            logic                  fwd_hit;
            logic [TAG_WIDTH-1:0]  fwd_tag;
            logic                  pend;
            logic [TAG_WIDTH-1:0]  tbl_tag;
            logic                  is_ref;
            logic [DATA_WIDTH-1:0] data;

            assign en      = (s == 0) ? src_en_1[k] : src_en_2[k];
            assign r       = (s == 0) ? src_addr_1[k*5 +: 5] : src_addr_2[k*5 +: 5];
            assign pend    = pend_q[r];
            assign tbl_tag = tag_q[r*TAG_WIDTH +: TAG_WIDTH];

            assign reg_read_en[P]          = in_valid & en;
            assign reg_read_addr[P*5 +: 5] = in_valid ? r : 5'd0;

            // Ascending scan: the last match is the highest older slot, i.e. the youngest writer.
            always_comb begin
                fwd_hit = 1'b0;
                fwd_tag = '0;
                for (int j = 0; j < k; j++) begin
                    if (slot_valid[j] && dst_en[j] && dst_addr[j*5 +: 5] == r) begin
                        fwd_hit = 1'b1;
                        fwd_tag = dst_tag[j*TAG_WIDTH +: TAG_WIDTH];
                    end
                end
            end

            always_comb begin
                is_ref = 1'b0;
                data   = '0;
                if (en && r != 5'd0) begin
                    if (fwd_hit) begin
                        is_ref = 1'b1;
                        data   = DATA_WIDTH'(fwd_tag);
                    end else if (pend && commit_en && commit_tag == tbl_tag) begin
                        data = commit_data;
                    end else if (pend) begin
                        is_ref = 1'b1;
                        data   = DATA_WIDTH'(tbl_tag);
                    end else begin
                        data = reg_read_data[P*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign is_ref_d[P]                       = is_ref;
            assign data_d[P*DATA_WIDTH +: DATA_WIDTH] = data;
        end
    end

    // Dispatch writes follow the commit clear so a same-cycle rename of the register wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            tag_q  <= '0;
        end else if (flush) begin
            pend_q <= '0;
        end else begin
            if (commit_en && pend_q[commit_addr] &&
                tag_q[commit_addr*TAG_WIDTH +: TAG_WIDTH] == commit_tag) begin
                pend_q[commit_addr] <= 1'b0;
            end
            if (accept) begin
                for (int k = 0; k < ISSUE_WIDTH; k++) begin
                    if (slot_valid[k] && dst_en[k] && dst_addr[k*5 +: 5] != 5'd0) begin
                        pend_q[dst_addr[k*5 +: 5]] <= 1'b1;
                        tag_q[dst_addr[k*5 +: 5]*TAG_WIDTH +: TAG_WIDTH] <=
                            dst_tag[k*TAG_WIDTH +: TAG_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            out_slot_valid <= '0;
            operand_is_ref <= '0;
            operand_data   <= '0;
        end else begin
            if (take) begin
                out_valid <= 1'b1;
            end else if (out_ready || flush) begin
                out_valid <= 1'b0;
            end
            if (take) begin
                out_slot_valid <= slot_valid;
                operand_is_ref <= is_ref_d;
                operand_data   <= data_d;
            end
        end
    end

endmodule

// File: tb/tb_operand_gen_multi.sv
// tb/tb_operand_gen_multi.sv - scoreboard bench for operand_gen_multi at two issue widths
module tb_operand_gen_multi;

    typedef struct packed {
        logic [3:0]   sv;
        logic [7:0]   rf;
        logic [255:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv2, iv4, ordy;
    logic [3:0]   sv, e1, e2, de;
    logic [19:0]  a1, a2, da;
    logic [15:0]  dt;
    logic         cen;
    logic [4:0]   caddr;
    logic [3:0]   ctag;
    logic [31:0]  cdata;
    logic         fl;

    logic         ir2, ov2;
    logic [3:0]   rre2, oref2;
    logic [19:0]  rra2;
    logic [127:0] rrd2, od2;
    logic [1:0]   osv2;

    logic         ir4, ov4;
    logic [7:0]   rre4, oref4;
    logic [39:0]  rra4;
    logic [255:0] rrd4, od4;
    logic [3:0]   osv4;

    int   total = 0;
    int   bad   = 0;
    exp_t q2[$];
    exp_t q4[$];
    exp_t cur;

    operand_gen_multi #(.ISSUE_WIDTH(2), .TAG_WIDTH(4), .DATA_WIDTH(32)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .slot_valid(sv[1:0]), .src_en_1(e1[1:0]), .src_en_2(e2[1:0]),
        .src_addr_1(a1[9:0]), .src_addr_2(a2[9:0]),
        .dst_en(de[1:0]), .dst_addr(da[9:0]), .dst_tag(dt[7:0]),
        .reg_read_en(rre2), .reg_read_addr(rra2), .reg_read_data(rrd2),
        .commit_en(cen), .commit_addr(caddr), .commit_tag(ctag), .commit_data(cdata),
        .flush(fl), .out_valid(ov2), .out_ready(ordy),
        .out_slot_valid(osv2), .operand_is_ref(oref2), .operand_data(od2)
    );

    operand_gen_multi #(.ISSUE_WIDTH(4), .TAG_WIDTH(4), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .slot_valid(sv), .src_en_1(e1), .src_en_2(e2),
        .src_addr_1(a1), .src_addr_2(a2),
        .dst_en(de), .dst_addr(da), .dst_tag(dt),
        .reg_read_en(rre4), .reg_read_addr(rra4), .reg_read_data(rrd4),
        .commit_en(cen), .commit_addr(caddr), .commit_tag(ctag), .commit_data(cdata),
        .flush(fl), .out_valid(ov4), .out_ready(ordy),
        .out_slot_valid(osv4), .operand_is_ref(oref4), .operand_data(od4)
    );

    // Register file contents; $0 is deliberately nonzero so a leak of its read data shows.
    function automatic logic [31:0] rfv(input logic [4:0] r);
        case (r)
            5'd0:    return 32'hDEAD_0000;
            5'd2:    return 32'd5;
            5'd3:    return 32'd7;
            default: return 32'h100 + {27'd0, r};
        endcase
    endfunction

    always_comb begin
        rrd2 = '0;
        for (int i = 0; i < 4; i++) rrd2[i*32 +: 32] = rfv(rra2[i*5 +: 5]);
    end

    always_comb begin
        rrd4 = '0;
        for (int i = 0; i < 8; i++) rrd4[i*32 +: 32] = rfv(rra4[i*5 +: 5]);
    end

    task automatic clear_in();
        sv = '0; e1 = '0; e2 = '0; de = '0;
        a1 = '0; a2 = '0; da = '0; dt = '0;
        cen = 1'b0; caddr = '0; ctag = '0; cdata = '0; fl = 1'b0;
        iv2 = 1'b0; iv4 = 1'b0;
        cur = '0;
    endtask

    task automatic slot(input int k, input bit en1, input int r1, input bit en2, input int r2,
                        input bit wen, input int rd, input int tg);
        sv[k] = 1'b1;
        e1[k] = en1; a1[k*5 +: 5] = 5'(r1);
        e2[k] = en2; a2[k*5 +: 5] = 5'(r2);
        de[k] = wen; da[k*5 +: 5] = 5'(rd); dt[k*4 +: 4] = 4'(tg);
        cur.sv[k] = 1'b1;
    endtask

    task automatic exp_op(input int k, input int s, input bit is_ref, input logic [31:0] v);
        cur.rf[2*k+s]         = is_ref;
        cur.d[(2*k+s)*32 +: 32] = v;
    endtask

    task automatic fire(input int w, input bit push);
        logic ir;
        if (w == 2) iv2 = 1'b1; else iv4 = 1'b1;
        #1;
        ir = (w == 2) ? ir2 : ir4;
        total++;
        if (ir !== 1'b1) begin
            bad++; $display("FAIL in_ready_w%0d got %b want 1", w, ir);
        end
        if (push) begin
            if (w == 2) q2.push_back(cur); else q4.push_back(cur);
        end
        @(posedge clk); #1;
        clear_in();
    endtask

    task automatic check(input int w, input string name, input bit peek);
        exp_t e;
        exp_t got;
        logic ov;
        if (w == 2) begin
            ov = ov2; got.sv = {2'b0, osv2}; got.rf = {4'b0, oref2}; got.d = {128'b0, od2};
        end else begin
            ov = ov4; got.sv = osv4; got.rf = oref4; got.d = od4;
        end
        total++;
        if (ov !== 1'b1) begin
            bad++; $display("FAIL %s out_valid got %b want 1", name, ov);
        end
        total++;
        if ((w == 2 && q2.size() == 0) || (w == 4 && q4.size() == 0)) begin
            bad++; $display("FAIL %s scoreboard got empty want entry", name);
            return;
        end
        if (w == 2) begin
            if (peek) e = q2[0]; else e = q2.pop_front();
        end else begin
            if (peek) e = q4[0]; else e = q4.pop_front();
        end
        total++;
        if (got.sv !== e.sv) begin
            bad++; $display("FAIL %s slot_valid got %b want %b", name, got.sv, e.sv);
        end
        total++;
        if (got.rf !== e.rf) begin
            bad++; $display("FAIL %s is_ref got %b want %b", name, got.rf, e.rf);
        end
        total++;
        if (got.d !== e.d) begin
            bad++; $display("FAIL %s data got %h want %h", name, got.d, e.d);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rst_ov2 got %b want 0", ov2); end
        total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL rst_ov4 got %b want 0", ov4); end
        total++; if (od2 !== '0) begin bad++; $display("FAIL rst_data got %h want 0", od2); end
        total++; if (oref2 !== '0) begin bad++; $display("FAIL rst_ref got %b want 0", oref2); end
        total++; if (osv2 !== '0) begin bad++; $display("FAIL rst_sv got %b want 0", osv2); end
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", ir2); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_in();
        slot(0, 1, 2, 1, 3, 1, 1, 1);
        exp_op(0, 0, 0, 32'd5);
        exp_op(0, 1, 0, 32'd7);
        iv2 = 1'b1;
        #1;
        total++; if (rre2 !== 4'b0011) begin bad++; $display("FAIL rd_en got %b want 0011", rre2); end
        total++;
        if (rra2 !== {10'd0, 5'd3, 5'd2}) begin
            bad++; $display("FAIL rd_addr got %h want %h", rra2, {10'd0, 5'd3, 5'd2});
        end
        fire(2, 1);
        check(2, "basic", 0);
        slot(0, 1, 2, 1, 3, 0, 0, 0);
        #1;
        total++; if (rre2 !== 4'b0000) begin bad++; $display("FAIL rd_en_idle got %b want 0000", rre2); end
        total++; if (rra2 !== '0) begin bad++; $display("FAIL rd_addr_idle got %h want 0", rra2); end
        clear_in();
    endtask

    task automatic test_in_group_fwd();
        slot(0, 1, 2, 1, 3, 1, 4, 3);
        slot(1, 1, 4, 1, 3, 1, 8, 5);
        exp_op(0, 0, 0, 32'd5);
        exp_op(0, 1, 0, 32'd7);
        exp_op(1, 0, 1, 32'd3);
        exp_op(1, 1, 0, 32'd7);
        fire(2, 1);
        check(2, "group_fwd", 0);
        slot(0, 1, 4, 0, 9, 0, 0, 0);
        exp_op(0, 0, 1, 32'd3);
        fire(2, 1);
        check(2, "table_ref", 0);
    endtask

    task automatic test_commit_fwd();
        slot(0, 1, 4, 0, 0, 0, 0, 0);
        cen = 1'b1; caddr = 5'd4; ctag = 4'd2; cdata = 32'h1234;
        exp_op(0, 0, 1, 32'd3);
        fire(2, 1);
        check(2, "commit_mismatch", 0);
        slot(0, 1, 4, 0, 0, 0, 0, 0);
        slot(1, 1, 8, 0, 0, 0, 0, 0);
        cen = 1'b1; caddr = 5'd4; ctag = 4'd3; cdata = 32'hABCD;
        exp_op(0, 0, 0, 32'hABCD);
        exp_op(1, 0, 1, 32'd5);
        fire(2, 1);
        check(2, "commit_fwd", 0);
        slot(0, 1, 4, 0, 0, 0, 0, 0);
        exp_op(0, 0, 0, 32'h104);
        fire(2, 1);
        check(2, "commit_cleared", 0);
    endtask

    task automatic test_stall();
        slot(0, 1, 2, 0, 0, 1, 9, 6);
        exp_op(0, 0, 0, 32'd5);
        fire(2, 1);
        ordy = 1'b0;
        slot(0, 1, 3, 0, 0, 1, 10, 7);
        iv2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ir2 !== 1'b0) begin bad++; $display("FAIL stall_in_ready got %b want 0", ir2); end
            check(2, "stall_hold", 1);
            @(posedge clk); #1;
        end
        clear_in();
        ordy = 1'b1;
        #1;
        check(2, "stall_release", 0);
        @(posedge clk); #1;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL stall_drain got %b want 0", ov2); end
        slot(0, 1, 10, 1, 9, 0, 0, 0);
        exp_op(0, 0, 0, 32'h10A);
        exp_op(0, 1, 1, 32'd6);
        fire(2, 1);
        check(2, "stall_no_write", 0);
    endtask

    task automatic test_flush();
        slot(0, 1, 2, 0, 0, 1, 5, 8);
        exp_op(0, 0, 0, 32'd5);
        fire(2, 1);
        check(2, "flush_pre", 0);
        slot(0, 0, 0, 0, 0, 1, 6, 9);
        fl = 1'b1;
        fire(2, 0);
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL flush_drop got %b want 0", ov2); end
        slot(0, 1, 5, 1, 6, 0, 0, 0);
        exp_op(0, 0, 0, 32'h105);
        exp_op(0, 1, 0, 32'h106);
        fire(2, 1);
        check(2, "flush_clear", 0);
    endtask

    task automatic test_reg0();
        slot(0, 1, 0, 1, 0, 1, 0, 10);
        slot(1, 1, 0, 0, 0, 0, 0, 0);
        fire(2, 1);
        check(2, "reg0_same", 0);
        slot(0, 1, 0, 0, 0, 0, 0, 0);
        fire(2, 1);
        check(2, "reg0_next", 0);
    endtask

    task automatic test_async_reset();
        slot(0, 0, 0, 0, 0, 1, 11, 12);
        fire(2, 1);
        ordy = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL arst_valid got %b want 0", ov2); end
        total++; if (osv2 !== '0) begin bad++; $display("FAIL arst_sv got %b want 0", osv2); end
        q2.delete();
        rst = 1'b1;
        ordy = 1'b1;
        @(posedge clk); #1;
        slot(0, 1, 11, 0, 0, 0, 0, 0);
        exp_op(0, 0, 0, 32'h10B);
        fire(2, 1);
        check(2, "arst_table", 0);
    endtask

    task automatic test_wide();
        slot(0, 0, 0, 0, 0, 1, 7, 4);
        slot(1, 1, 7, 1, 2, 0, 0, 0);
        slot(2, 0, 0, 0, 0, 1, 7, 11);
        slot(3, 1, 7, 0, 0, 0, 0, 0);
        exp_op(1, 0, 1, 32'd4);
        exp_op(1, 1, 0, 32'd5);
        exp_op(3, 0, 1, 32'd11);
        iv4 = 1'b1;
        #1;
        total++; if (rre4 !== 8'b0100_1100) begin bad++; $display("FAIL wide_rd_en got %b want 01001100", rre4); end
        fire(4, 1);
        check(4, "wide_fwd", 0);
        slot(0, 1, 7, 0, 0, 0, 0, 0);
        exp_op(0, 0, 1, 32'd11);
        fire(4, 1);
        check(4, "wide_table", 0);
    endtask

    initial begin
        clear_in();
        ordy = 1'b1;
        rst  = 1'b0;
        test_reset();
        test_basic();
        test_in_group_fwd();
        test_commit_fwd();
        test_stall();
        test_flush();
        test_reg0();
        test_async_reset();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
